// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the 32-bit multicycle processor
module multicycle_control #(
  parameter logic [5:0] OPC_RTYPE = 6'h00,
  parameter logic [5:0] OPC_LW    = 6'h23,
  parameter logic [5:0] OPC_SW    = 6'h2B,
  parameter logic [5:0] OPC_BEQ   = 6'h04,
  parameter logic [5:0] OPC_J     = 6'h02,
  parameter logic [5:0] OPC_ADDI  = 6'h08
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal_op,
  output logic [31:0] instr_count,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  // Moore part of the control word; ir_write and the FETCH pc_write are added combinationally
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;
  logic   illegal_set;
  logic   retire;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_R_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ADDI_WB: c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection, plus the retire and illegal-opcode events of this cycle
  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    retire      = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OPC_LW || opcode == OPC_SW) state_d = S_MEM_ADDR;
        else if (opcode == OPC_RTYPE)             state_d = S_EXECUTE;
        else if (opcode == OPC_BEQ)               state_d = S_BRANCH;
        else if (opcode == OPC_J)                 state_d = S_JUMP;
        else if (opcode == OPC_ADDI)              state_d = S_ADDI_EXEC;
        else begin
          illegal_set = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_MEM_ADDR: state_d = (opcode == OPC_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State, registered control word, sticky illegal flag and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      illegal_op  <= 1'b0;
      instr_count <= 32'd0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
      if (illegal_set) illegal_op <= 1'b1;
      if (retire) instr_count <= instr_count + 32'd1;
    end
  end

  assign ir_write      = (state_q == S_FETCH) && mem_ready;
  assign pc_write      = ctrl_q.pc_write | ir_write;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_dst       = ctrl_q.reg_dst;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_source     = ctrl_q.pc_source;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [31:0] instr_count;
  logic [3:0]  state;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .instr_count(instr_count),
    .state(state)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  logic [15:0] act_ctrl;
  assign act_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [31:0] cnt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic        exp_ill = 1'b0;

  // Control word expected in each state, written out from the state table
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
    case (st)
      4'd1:  return {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
      4'd2:  return 16'b0000_0000_0011_0000;
      4'd3:  return 16'b0000_0000_0110_0000;
      4'd4:  return 16'b0011_0000_0000_0000;
      4'd5:  return 16'b0000_0010_1000_0000;
      4'd6:  return 16'b0010_1000_0000_0000;
      4'd7:  return 16'b0000_0000_0100_1000;
      4'd8:  return 16'b0000_0001_1000_0000;
      4'd9:  return 16'b0100_0000_0100_0101;
      4'd10: return 16'b1000_0000_0000_0010;
      4'd11: return 16'b0000_0000_0110_0000;
      4'd12: return 16'b0000_0000_1000_0000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [5:0] op, input logic mr, input logic [3:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = mr;
    e.st   = st;
    e.ctrl = exp_ctrl(st, mr);
    e.cnt  = exp_cnt;
    e.ill  = exp_ill;
    q.push_back(e);
  endtask

  task automatic release_reset();
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    e.st   = 4'd0;
    e.ctrl = 16'h0000;
    e.cnt  = 32'd0;
    e.ill  = 1'b0;
    q.push_back(e);
  endtask

  // Monitor: compares the DUT against the oldest pending expectation each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("state", {28'd0, state}, {28'd0, e.st});
        check($sformatf("ctrl@st%0d", e.st), {16'd0, act_ctrl}, {16'd0, e.ctrl});
        check("instr_count", instr_count, e.cnt);
        check("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
        check("no_memwr_regwr", {31'd0, mem_write & reg_write}, 32'd0);
        check("no_memrd_memwr", {31'd0, mem_read & mem_write}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_ctrl", {16'd0, act_ctrl}, 32'd0);
    release_reset();

    // R-type: FETCH, DECODE, EXECUTE, R_WB
    cyc(6'h00, 1'b1, 4'd1);
    cyc(6'h00, 1'b1, 4'd2);
    cyc(6'h00, 1'b1, 4'd7);
    cyc(6'h00, 1'b1, 4'd8);
    exp_cnt++;

    // LW with FETCH stall and MEM_READ wait
    cyc(6'h23, 1'b0, 4'd1);
    cyc(6'h23, 1'b0, 4'd1);
    cyc(6'h23, 1'b1, 4'd1);
    cyc(6'h23, 1'b1, 4'd2);
    cyc(6'h23, 1'b0, 4'd3);
    cyc(6'h23, 1'b0, 4'd4);
    cyc(6'h23, 1'b0, 4'd4);
    cyc(6'h23, 1'b0, 4'd4);
    cyc(6'h23, 1'b1, 4'd4);
    cyc(6'h23, 1'b1, 4'd5);
    exp_cnt++;

    // SW with one wait cycle in MEM_WRITE
    cyc(6'h2B, 1'b1, 4'd1);
    cyc(6'h2B, 1'b1, 4'd2);
    cyc(6'h2B, 1'b1, 4'd3);
    cyc(6'h2B, 1'b0, 4'd6);
    cyc(6'h2B, 1'b1, 4'd6);
    exp_cnt++;

    // BEQ
    cyc(6'h04, 1'b1, 4'd1);
    cyc(6'h04, 1'b1, 4'd2);
    cyc(6'h04, 1'b1, 4'd9);
    exp_cnt++;

    // J
    cyc(6'h02, 1'b1, 4'd1);
    cyc(6'h02, 1'b1, 4'd2);
    cyc(6'h02, 1'b1, 4'd10);
    exp_cnt++;

    // ADDI
    cyc(6'h08, 1'b1, 4'd1);
    cyc(6'h08, 1'b1, 4'd2);
    cyc(6'h08, 1'b1, 4'd11);
    cyc(6'h08, 1'b1, 4'd12);
    exp_cnt++;

    // Illegal opcode: flag set, no retire, back to FETCH
    cyc(6'h3F, 1'b1, 4'd1);
    cyc(6'h3F, 1'b1, 4'd2);
    exp_ill = 1'b1;

    // Flag stays set across a later R-type
    cyc(6'h00, 1'b1, 4'd1);
    cyc(6'h00, 1'b1, 4'd2);
    cyc(6'h00, 1'b1, 4'd7);
    cyc(6'h00, 1'b1, 4'd8);
    exp_cnt++;
    cyc(6'h00, 1'b1, 4'd1);

    // Asynchronous reset while FETCH drives ir_write/pc_write
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", {28'd0, state}, 32'd0);
    check("async_rst_ctrl", {16'd0, act_ctrl}, 32'd0);
    check("async_rst_cnt", instr_count, 32'd0);
    check("async_rst_ill", {31'd0, illegal_op}, 32'd0);
    exp_cnt = 32'd0;
    exp_ill = 1'b0;
    release_reset();
    cyc(6'h02, 1'b1, 4'd1);
    cyc(6'h02, 1'b1, 4'd2);
    cyc(6'h02, 1'b1, 4'd10);
    exp_cnt++;
    cyc(6'h02, 1'b0, 4'd1);

    k = 0;
    while (q.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM of the 32-bit multicycle processor.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives the select lines of every datapath mux (mux_1bit and 4-input muxes) and the write enables of the PC, IR, register file and memory.
- Sits directly upstream of the datapath muxes. Consumes the IR opcode field and a memory-ready handshake.

Parameters:
- OPC_RTYPE, 6'h00, R-type opcode
- OPC_LW, 6'h23, load word opcode
- OPC_SW, 6'h2B, store word opcode
- OPC_BEQ, 6'h04, branch-equal opcode
- OPC_J, 6'h02, jump opcode
- OPC_ADDI, 6'h08, add-immediate opcode

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory has completed the current read/write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero
- i_or_d  output  1  memory address mux select (0=PC, 1=ALUOut)
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load
- mem_to_reg  output  1  writeback mux select (0=ALUOut, 1=MDR)
- reg_dst  output  1  destination mux select (0=rt, 1=rd)
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A mux select (0=PC, 1=A reg)
- alu_src_b  output  2  ALU B mux select (00=B, 01=const 4, 10=sign-ext imm, 11=imm<<2)
- alu_op  output  2  00=add, 01=sub, 10=funct-decoded
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal_op  output  1  sticky flag, unknown opcode decoded
- instr_count  output  32  count of retired instructions
- state  output  4  current state, for debug

Behaviour:
- State register is async-cleared by rst_n=0 to IDLE (0). In IDLE all outputs are 0, illegal_op=0 and instr_count=0.
- IDLE always moves to FETCH on the next clk.
- Encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12. Codes 13-15 recover to FETCH.
- Outputs are decoded from the current state. Signals not listed for a state are 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write = mem_ready (the only Mealy terms).
  - Holds in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: LW/SW→MEM_ADDR, RTYPE→EXECUTE, BEQ→BRANCH, J→JUMP, ADDI→ADDI_EXEC.
  - Any other opcode: illegal_op←1 (sticky until reset), next state FETCH, instr_count not incremented.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_READ if LW, MEM_WRITE if SW.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready=1, then MEM_WB.
- MEM_WB: mem_to_reg=1, reg_dst=0, reg_write=1. Next state FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready=1, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next state FETCH.
- JUMP: pc_write=1, pc_source=10. Next state FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1. Next state FETCH.
- instr_count increments by 1 on each clk edge leaving MEM_WB, MEM_WRITE (with mem_ready=1), R_WB, BRANCH, JUMP or ADDI_WB. It wraps 32'hFFFFFFFF→0.
- Cycle counts with mem_ready held at 1: R/ADDI 4, LW 5, SW 4, BEQ 3, J 3.
- mem_write and reg_write are never both 1. mem_read and mem_write are never both 1.
- Reset mid-instruction: outputs drop to 0 immediately (asynchronously), with no partial write.

Test Plan:
- Reset: rst_n=0 in any state → state=0 and all outputs 0 asynchronously. After release, FETCH follows 1 clk later with mem_read=1.
- R-type, opcode=6'h00, mem_ready=1: states 1,2,7,8,1. reg_write=1 and reg_dst=1 only in state 8. instr_count 0→1.
- LW, opcode=6'h23: mem_ready=0 for 3 cycles in MEM_READ → state stays 4, mem_read=1, i_or_d=1. Then mem_ready=1 → MEM_WB with mem_to_reg=1 and reg_write=1.
- FETCH stall: mem_ready=0 → ir_write=0 and pc_write=0, state held at 1. mem_ready=1 → ir_write=1 and pc_write=1 in that same cycle.
- BEQ 6'h04 → pc_write_cond=1, pc_source=01, alu_op=01 in state 9. J 6'h02 → pc_write=1, pc_source=10 in state 10.
- Illegal opcode 6'h3F → illegal_op=1 and stays 1 across later instructions, instr_count unchanged, back to FETCH. Reset clears illegal_op.
